flow_ctrl: RTL and testbench
============================

# flow_ctrl

Control front-end for the flowing-LED display. Synchronises and debounces two push-buttons and turns them into a run enable and a speed level. Generates the single-cycle step strobe that advances the LED shifter downstream. Replaces the free-running divided clock with a clock enable in the main clock domain, so the shifter runs on `clk` and steps only when `step` is high.

## Interface
- `DEB_CYCLES`, 1_000_000: debounce stability window in `clk` cycles (20 ms at 50 MHz); must be ≥ 2.
- `DIV_BASE`, 25_000_000: step period at speed 0, in `clk` cycles; must be ≥ 8 and divisible by 8.
- `clk`, in, 1: system clock. One clock only.
- `rst`, in, 1: reset; synchronous, active-high.
- `btn_run`, in, 1: raw run/stop button, asynchronous, active-high.
- `btn_speed`, in, 1: raw speed button, asynchronous, active-high.
- `en`, out, 1: run enable to the LED shifter.
- `step`, out, 1: one-cycle advance strobe; high only while `en` is high.
- `speed`, out, 2: current speed level, 0 (slowest) to 3.

## Operation
- **Synchroniser:** each button passes through a two-flop synchroniser, giving `s2`.
- **Debounce:** each button has a counter and a `stable` flag.
  - When `s2 == stable`, the counter clears.
  - When `s2 != stable`, the counter increments.
  - When the counter is at `DEB_CYCLES-1` and the mismatch is still present, `stable <= s2` and the counter clears.
  - A glitch shorter than `DEB_CYCLES` cycles produces no change.
- **Press:** `press = stable & ~stable_q`, combinational, one cycle wide. Release produces nothing.
- **Run press:** `en <= ~en`.
- **Speed press:** `speed <= speed + 1`, modulo 4 (3 wraps to 0).
- **Prescaler:** `period = DIV_BASE >> speed`.
  - While `en` is high, `cnt` counts 0..`period-1`, then wraps.
  - `step` is registered high in the cycle after `cnt` reaches `period-1`.
  - While `en` is low, `cnt` holds 0 and `step` is 0.
- **Prescaler clears:** `cnt` clears on the edge where `en` changes and on the edge where `speed` changes. The next step therefore comes a full new period later, with no short or long step.
- **Simultaneous presses:** both take effect on the same edge, and `cnt` clears.
- **Stop:** if `en` falls in the same edge `cnt` hits terminal, `step` is 0. No step is ever issued while `en` is low.

## Timing
- **Reset values:** `en=0`, `step=0`, `speed=0`; synchroniser flops, `stable`, `stable_q`, debounce counters and `cnt` all 0.
- **Reset mid-operation:** reset dominates every other action on that edge.
- **Press latency:** raw button high and steady from edge 0 gives:
  - `s2=1` after edge 2;
  - `stable=1` after edge `2+DEB_CYCLES`;
  - `en`/`speed` updated after edge `3+DEB_CYCLES`.
- **First step:** after `en` rises at edge E, the first `step` is high in the cycle after edge `E+period`.
- **Step repetition:** subsequent steps are exactly `period` cycles apart. `step` is never high two consecutive cycles.
- **Release latency:** a release needs `DEB_CYCLES` stable cycles before a new press can be detected.

## Structure
- **Shared package `flow_pkg`:**
  - `SPEED_W = 2`;
  - `NUM_SPEEDS = 4`;
  - `LED_W = 6`, shared with the LED shifter;
  - default `DEB_CYCLES` / `DIV_BASE` constants.
- **Sub-module `btn_debounce`:** synchroniser, debounce counter, `stable`, and the `press` output. Instantiated twice.
- **Top level:** `en`/`speed` registers and the prescaler.

## Test plan
All scenarios use `DEB_CYCLES=4`, `DIV_BASE=64`.
- **Reset:** assert `rst` for 3 cycles → `en=0`, `speed=0`, `step=0`; no `step` for 200 cycles afterwards.
- **Run press:** `btn_run` high for 10 cycles → `en` rises after edge 7, once; steps at period 64, first 64 cycles after `en` rose; `btn_run` pressed again → `en=0` and `step` stays 0.
- **Glitch rejection:** `btn_speed` high for 3 cycles, then low → `speed` stays 0. `btn_speed` bouncing 1-0-1, then high for 10 → exactly one increment.
- **Speed sweep:** four speed presses while running → `speed` goes 1, 2, 3, 0; step periods 32, 16, 8, 64; the first step after each change comes one full new period later.
- **Simultaneous:** both buttons pressed on the same cycle while stopped → `en=1` and `speed=1` on the same edge; first step 32 cycles later.
- **Reset mid-run:** `rst` pulsed at `speed=2` with `cnt` mid-period → all outputs at reset values on the next edge; no stray `step`.

Source files
------------

// File: rtl/flow_pkg.sv
`default_nettype none
// flow_pkg: shared widths and defaults for the flowing-LED control path. Rev 1.0
package flow_pkg;
  localparam int SPEED_W        = 2;
  localparam int NUM_SPEEDS     = 4;
  localparam int LED_W          = 6;
  localparam int DEF_DEB_CYCLES = 1_000_000;
  localparam int DEF_DIV_BASE   = 25_000_000;

  typedef logic [SPEED_W-1:0] speed_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// btn_debounce: two-flop synchroniser, stability-window debounce and one-cycle press pulse. Rev 1.0
module btn_debounce
  import flow_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  localparam int            CW   = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          stable;
  logic          stable_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
    end else begin
      s1       <= btn;
      s2       <= s1;
      stable_q <= stable;
      // Any return to agreement restarts the window, so short glitches are dropped.
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign press = stable & ~stable_q;
endmodule
`default_nettype wire

// File: rtl/flow_ctrl.sv
`default_nettype none
// flow_ctrl: button front-end producing run enable, speed level and the clock-enable step strobe. Rev 1.0
module flow_ctrl
  import flow_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int DIV_BASE   = DEF_DIV_BASE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_run,
  input  logic               btn_speed,
  output logic               en,
  output logic               step,
  output logic [SPEED_W-1:0] speed
);
  localparam int CNT_W = cnt_width(DIV_BASE);

  logic             press_run;
  logic             press_speed;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] term;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_run),
    .press (press_run)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_speed (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_speed),
    .press (press_speed)
  );

  always_comb begin
    term = CNT_W'((DIV_BASE >> speed) - 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en    <= 1'b0;
      speed <= '0;
      cnt   <= '0;
      step  <= 1'b0;
    end else begin
      if (press_run) begin
        en <= ~en;
      end
      if (press_speed) begin
        speed <= speed + SPEED_W'(1);
      end
      // A mode change restarts the period so no shortened or stretched step escapes.
      if (press_run || press_speed) begin
        cnt  <= '0;
        step <= 1'b0;
      end else if (en) begin
        if (cnt == term) begin
          cnt  <= '0;
          step <= 1'b1;
        end else begin
          cnt  <= cnt + CNT_W'(1);
          step <= 1'b0;
        end
      end else begin
        cnt  <= '0;
        step <= 1'b0;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_flow_ctrl.sv
`default_nettype none
// tb_flow_ctrl: directed self-checking bench for flow_ctrl with DEB_CYCLES=4, DIV_BASE=64. Rev 1.0
module tb_flow_ctrl;
  localparam int DEB = 4;
  localparam int DIV = 64;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       btn_run   = 1'b0;
  logic       btn_speed = 1'b0;
  logic       en;
  logic       step;
  logic [1:0] speed;

  int   checks    = 0;
  int   errors    = 0;
  int   step_cnt  = 0;
  int   dbl_cnt   = 0;
  int   stray_cnt = 0;
  int   base      = 0;
  logic prev_step = 1'b0;

  flow_ctrl #(.DEB_CYCLES(DEB), .DIV_BASE(DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_run   (btn_run),
    .btn_speed (btn_speed),
    .en        (en),
    .step      (step),
    .speed     (speed)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (step === 1'b1) begin
      step_cnt = step_cnt + 1;
      if (prev_step === 1'b1) dbl_cnt = dbl_cnt + 1;
      if (en !== 1'b1) stray_cnt = stray_cnt + 1;
    end
    prev_step = step;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns three edges after en toggles (edge E+3), button released.
  task automatic press_run(input logic exp_en);
    btn_run = 1'b1;
    wait_edges(6);
    check("en_hold", en, !exp_en);
    wait_edges(1);
    check("en_toggle", en, exp_en);
    wait_edges(3);
    btn_run = 1'b0;
  endtask

  // Speed changes at edge S; checks the first two steps at S+p and S+2p.
  task automatic speed_press(input int exp_spd, input int p);
    btn_speed = 1'b1;
    wait_edges(6);
    check("speed_hold", speed, (exp_spd + 3) % 4);
    wait_edges(1);
    check("speed_inc", speed, exp_spd);
    base = step_cnt;
    wait_edges(3);
    btn_speed = 1'b0;
    wait_edges(p - 4);
    check("no_early_step", step_cnt - base, 0);
    check("step_pre", step, 0);
    wait_edges(1);
    check("step_first", step, 1);
    wait_edges(p - 1);
    check("step_gap", step, 0);
    wait_edges(1);
    check("step_second", step, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: timeout reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    wait_edges(3);
    check("rst_en", en, 0);
    check("rst_speed", speed, 0);
    check("rst_step", step, 0);
    rst = 1'b0;
    base = step_cnt;
    wait_edges(200);
    check("idle_no_step", step_cnt - base, 0);

    // Run press, period 64
    press_run(1'b1);
    wait_edges(60);
    check("run_step_pre", step, 0);
    wait_edges(1);
    check("run_step_first", step, 1);
    wait_edges(1);
    check("run_step_width", step, 0);
    wait_edges(62);
    check("run_step_gap", step, 0);
    wait_edges(1);
    check("run_step_second", step, 1);

    // Stop
    press_run(1'b0);
    base = step_cnt;
    wait_edges(150);
    check("stop_en", en, 0);
    check("stop_no_step", step_cnt - base, 0);

    // Glitch rejection
    btn_speed = 1'b1;
    wait_edges(3);
    btn_speed = 1'b0;
    wait_edges(20);
    check("glitch_speed", speed, 0);
    btn_speed = 1'b1;
    wait_edges(1);
    btn_speed = 1'b0;
    wait_edges(1);
    btn_speed = 1'b1;
    wait_edges(10);
    btn_speed = 1'b0;
    wait_edges(20);
    check("bounce_speed", speed, 1);

    // Speed sweep while running
    rst = 1'b1;
    wait_edges(1);
    rst = 1'b0;
    check("rst2_speed", speed, 0);
    press_run(1'b1);
    wait_edges(20);
    speed_press(1, 32);
    speed_press(2, 16);
    speed_press(3, 8);
    speed_press(0, 64);

    // Simultaneous presses while stopped
    rst = 1'b1;
    wait_edges(1);
    rst = 1'b0;
    btn_run   = 1'b1;
    btn_speed = 1'b1;
    wait_edges(6);
    check("sim_en_hold", en, 0);
    check("sim_speed_hold", speed, 0);
    wait_edges(1);
    check("sim_en", en, 1);
    check("sim_speed", speed, 1);
    wait_edges(3);
    btn_run   = 1'b0;
    btn_speed = 1'b0;
    wait_edges(28);
    check("sim_step_pre", step, 0);
    wait_edges(1);
    check("sim_step_first", step, 1);

    // Reset mid-run at speed 2
    wait_edges(20);
    speed_press(2, 16);
    wait_edges(7);
    rst = 1'b1;
    wait_edges(1);
    check("midrst_en", en, 0);
    check("midrst_speed", speed, 0);
    check("midrst_step", step, 0);
    rst = 1'b0;
    base = step_cnt;
    wait_edges(100);
    check("midrst_no_step", step_cnt - base, 0);

    check("never_double_step", dbl_cnt, 0);
    check("never_step_while_stopped", stray_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
